control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_if.sv | 37 +++
 rtl/control_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_control_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// control_unit_if: control unit <-> datapath/program-counter signal bundle.
// master = control unit, slave = datapath side.
interface control_unit_if;
  logic        start;
  logic [7:0]  Dec_IN;
  logic        z_flag;
  logic        finish_signal;
  logic [2:0]  Op;
  logic [3:0]  shift;
  logic        fetch;
  logic        Decode;
  logic        PC1;
  logic        Read_AC;
  logic        Mem_Read;
  logic        Mem_Write;
  logic [1:0]  Ins_Con;
  logic [14:0] Read_RL;
  logic [17:0] Write_RL;
  logic        busy;
  logic        done;

  modport master (
    input  start, Dec_IN, z_flag, finish_signal,
    output Op, shift, fetch, Decode, PC1,
    output Read_AC, Mem_Read, Mem_Write,
    output Ins_Con, Read_RL, Write_RL,
    output busy, done
  );

  modport slave (
    output start, Dec_IN, z_flag, finish_signal,
    input  Op, shift, fetch, Decode, PC1,
    input  Read_AC, Mem_Read, Mem_Write,
    input  Ins_Con, Read_RL, Write_RL,
    input  busy, done
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: multi-cycle accumulator CPU sequencer with registered strobes.
// Macro CU_ZERO_BRANCH_EN enables the JMPZ/JMPNZ branch path.
module control_unit (
  input  logic          clk,
  input  logic          rst_n,
  control_unit_if.master cu
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOADIR, S_DECODE,
    S_FETCHOP, S_EXEC, S_MEM, S_HALT
  } state_t;

`ifdef CU_ZERO_BRANCH_EN
  localparam bit BrEn = 1'b1;
`else
  localparam bit BrEn = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [3:0]  opc_q, opc_d;
  logic [3:0]  n_q, n_d;
  logic        fetch_q, fetch_d;
  logic        decode_q, decode_d;
  logic        pc1_q, pc1_d;
  logic        rd_ac_q, rd_ac_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic        ar_ld_q, ar_ld_d;
  logic        jmp_q, jmp_d;
  logic [2:0]  op_q, op_d;
  logic [3:0]  shift_q, shift_d;
  logic [14:0] rrl_q, rrl_d;
  logic [17:0] wrl_q, wrl_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        busy_now;
  logic        reg_ok;
  logic        is_br;
  logic        take;
  logic [4:0]  wr_idx;

  assign busy_now = (state_q != S_IDLE) &&
                    (state_q != S_HALT);

  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    n_d      = n_q;
    fetch_d  = 1'b0;
    decode_d = 1'b0;
    pc1_d    = 1'b0;
    rd_ac_d  = 1'b0;
    mem_rd_d = 1'b0;
    mem_wr_d = 1'b0;
    ar_ld_d  = 1'b0;
    jmp_d    = 1'b0;
    op_d     = 3'b000;
    shift_d  = 4'd0;
    rrl_d    = '0;
    wrl_d    = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    if (state_q == S_DECODE) begin
      opc_d = cu.Dec_IN[7:4];
      n_d   = cu.Dec_IN[3:0];
    end

    reg_ok = (n_d < 4'd12);
    is_br  = BrEn &&
             ((opc_d == 4'hA) || (opc_d == 4'hB));
    wr_idx = {1'b0, n_d} + 5'd1;

    unique case (state_q)
      S_IDLE, S_HALT:
        if (cu.start) state_d = S_FETCH;
      S_FETCH:   state_d = S_LOADIR;
      S_LOADIR:  state_d = S_DECODE;
      S_DECODE:  state_d = is_br ? S_FETCHOP : S_EXEC;
      S_FETCHOP: state_d = S_EXEC;
      S_EXEC:
        unique case (1'b1)
          (opc_q == 4'h8),
          (opc_q == 4'h9): state_d = S_MEM;
          (opc_q == 4'hF): state_d = S_HALT;
          default:         state_d = S_FETCH;
        endcase
      S_MEM:     state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase

    if (busy_now && cu.finish_signal)
      state_d = S_HALT;

    // Strobes are decoded for the state being entered so they are registered.
    unique case (state_d)
      S_FETCH, S_FETCHOP: begin
        fetch_d = 1'b1;
        pc1_d   = 1'b1;
      end
      S_LOADIR: begin
        rrl_d[12] = 1'b1;
        wrl_d[14] = 1'b1;
      end
      S_DECODE: decode_d = 1'b1;
      S_EXEC:
        unique case (opc_d)
          4'h1: if (reg_ok) begin
            rrl_d[n_d] = 1'b1;
            wrl_d[0]   = 1'b1;
          end
          4'h2: if (reg_ok) begin
            rd_ac_d       = 1'b1;
            wrl_d[wr_idx] = 1'b1;
          end
          4'h3, 4'h4: if (reg_ok) begin
            op_d       = (opc_d == 4'h3) ? 3'b001 : 3'b010;
            rd_ac_d    = 1'b1;
            rrl_d[n_d] = 1'b1;
            wrl_d[0]   = 1'b1;
          end
          4'h5, 4'h6: begin
            op_d     = (opc_d == 4'h5) ? 3'b011 : 3'b100;
            shift_d  = n_d;
            rd_ac_d  = 1'b1;
            wrl_d[0] = 1'b1;
          end
          4'h7: if (reg_ok) begin
            op_d          = 3'b101;
            rrl_d[n_d]    = 1'b1;
            wrl_d[wr_idx] = 1'b1;
          end
          4'h8: mem_rd_d = 1'b1;
          4'h9: begin
            rd_ac_d   = 1'b1;
            wrl_d[16] = 1'b1;
          end
          4'hA, 4'hB: jmp_d = is_br;
          4'hC: begin
            ar_ld_d   = 1'b1;
            wrl_d[17] = 1'b1;
          end
          4'hD: begin
            rd_ac_d   = 1'b1;
            wrl_d[15] = 1'b1;
          end
          4'hE: begin
            op_d     = 3'b110;
            wrl_d[0] = 1'b1;
          end
          default: ;
        endcase
      S_MEM:
        if (opc_d == 4'h8) begin
          rrl_d[14] = 1'b1;
          wrl_d[0]  = 1'b1;
        end else begin
          mem_wr_d = 1'b1;
        end
      S_HALT:  done_d = 1'b1;
      default: ;
    endcase

    busy_d = (state_d != S_IDLE) &&
             (state_d != S_HALT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opc_q    <= 4'd0;
      n_q      <= 4'd0;
      fetch_q  <= 1'b0;
      decode_q <= 1'b0;
      pc1_q    <= 1'b0;
      rd_ac_q  <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      ar_ld_q  <= 1'b0;
      jmp_q    <= 1'b0;
      op_q     <= 3'b000;
      shift_q  <= 4'd0;
      rrl_q    <= '0;
      wrl_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opc_q    <= opc_d;
      n_q      <= n_d;
      fetch_q  <= fetch_d;
      decode_q <= decode_d;
      pc1_q    <= pc1_d;
      rd_ac_q  <= rd_ac_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      ar_ld_q  <= ar_ld_d;
      jmp_q    <= jmp_d;
      op_q     <= op_d;
      shift_q  <= shift_d;
      rrl_q    <= rrl_d;
      wrl_q    <= wrl_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // The branch condition must see z_flag during EXEC itself.
  assign take = jmp_q &
                ((opc_q == 4'hA) ? cu.z_flag : ~cu.z_flag);

  assign cu.Op        = op_q;
  assign cu.shift     = shift_q;
  assign cu.fetch     = fetch_q;
  assign cu.Decode    = decode_q;
  assign cu.PC1       = pc1_q;
  assign cu.Read_AC   = rd_ac_q;
  assign cu.Mem_Read  = mem_rd_q;
  assign cu.Mem_Write = mem_wr_q;
  assign cu.Ins_Con   = {take, ar_ld_q};
  assign cu.Read_RL   = rrl_q;
  assign cu.Write_RL  = wrl_q | {4'b0, take, 13'b0};
  assign cu.busy      = busy_q;
  assign cu.done      = done_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed-vector bench for control_unit.
// Branch expectations follow CU_ZERO_BRANCH_EN.
module tb_control_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;

  control_unit_if cu ();
  control_unit dut (.clk(clk), .rst_n(rst_n), .cu(cu));

  always #5 clk = ~clk;

  function automatic logic [49:0] outs();
    return {cu.Op, cu.shift, cu.fetch, cu.Decode, cu.PC1,
            cu.Read_AC, cu.Mem_Read, cu.Mem_Write, cu.Ins_Con,
            cu.Read_RL, cu.Write_RL, cu.busy, cu.done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic launch(input logic [7:0] d);
    cu.Dec_IN = d;
    cu.start = 1'b1;
    step();
    cu.start = 1'b0;
  endtask

  task automatic to_exec(input logic [7:0] d);
    launch(d);
    step();
    step();
    step();
  endtask

  task automatic test_reset();
    do_reset();
    step();
    tests++; if (outs() !== 50'h0) begin fails++; $display("FAIL reset_idle got %h want 0", outs()); end
    to_exec(8'h35);
    tests++; if (cu.Op !== 3'b001) begin fails++; $display("FAIL add_op got %0h want 1", cu.Op); end
    tests++; if (cu.Read_RL !== 15'h0020) begin fails++; $display("FAIL add_rrl got %h want 0020", cu.Read_RL); end
    rst_n = 1'b0;
    step(); step(); step();
    tests++; if (outs() !== 50'h0) begin fails++; $display("FAIL reset_exec got %h want 0", outs()); end
    rst_n = 1'b1;
    step();
    tests++; if (cu.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", cu.busy); end
  endtask

  task automatic test_ldac();
    do_reset();
    launch(8'h13);
    tests++; if ({cu.fetch, cu.PC1, cu.busy} !== 3'b111) begin fails++; $display("FAIL fetch got %b want 111", {cu.fetch, cu.PC1, cu.busy}); end
    step();
    tests++; if (cu.Read_RL !== 15'h1000 || cu.Write_RL !== 18'h04000) begin fails++; $display("FAIL loadir got %h/%h want 1000/04000", cu.Read_RL, cu.Write_RL); end
    step();
    tests++; if (cu.Decode !== 1'b1) begin fails++; $display("FAIL decode got %b want 1", cu.Decode); end
    step();
    tests++; if (cu.Read_RL !== 15'h0008 || cu.Write_RL !== 18'h1 || cu.Op !== 3'b000) begin fails++; $display("FAIL ldac got %h/%h/%0h want 0008/00001/0", cu.Read_RL, cu.Write_RL, cu.Op); end
    step();
    tests++; if (cu.fetch !== 1'b1) begin fails++; $display("FAIL ldac_cpi got %b want 1", cu.fetch); end
  endtask

  task automatic test_alu();
    do_reset();
    to_exec(8'h53);
    tests++; if ({cu.Op, cu.shift, cu.Read_AC} !== {3'b011, 4'd3, 1'b1} || cu.Write_RL !== 18'h1) begin fails++; $display("FAIL shr got %b/%h want 011_0011_1/00001", {cu.Op, cu.shift, cu.Read_AC}, cu.Write_RL); end
    step();
    tests++; if (cu.shift !== 4'd0) begin fails++; $display("FAIL shr_after got %0d want 0", cu.shift); end
    do_reset();
    to_exec(8'h62);
    tests++; if ({cu.Op, cu.shift} !== {3'b100, 4'd2}) begin fails++; $display("FAIL shl got %b want 100_0010", {cu.Op, cu.shift}); end
    do_reset();
    to_exec(8'h25);
    tests++; if (cu.Write_RL !== 18'h00040 || cu.Read_AC !== 1'b1) begin fails++; $display("FAIL stac got %h/%b want 00040/1", cu.Write_RL, cu.Read_AC); end
    do_reset();
    to_exec(8'h2B);
    tests++; if (cu.Write_RL !== 18'h01000) begin fails++; $display("FAIL stac_r11 got %h want 01000", cu.Write_RL); end
    do_reset();
    to_exec(8'h1C);
    tests++; if (cu.Read_RL !== 15'h0 || cu.Write_RL !== 18'h0) begin fails++; $display("FAIL ldac_n12 got %h/%h want 0/0", cu.Read_RL, cu.Write_RL); end
    do_reset();
    to_exec(8'h74);
    tests++; if (cu.Op !== 3'b101 || cu.Write_RL !== 18'h00020) begin fails++; $display("FAIL inc got %0h/%h want 5/00020", cu.Op, cu.Write_RL); end
    do_reset();
    to_exec(8'hC0);
    tests++; if (cu.Ins_Con !== 2'b01 || cu.Write_RL !== 18'h20000) begin fails++; $display("FAIL ldar got %b/%h want 01/20000", cu.Ins_Con, cu.Write_RL); end
    do_reset();
    to_exec(8'hD0);
    tests++; if (cu.Write_RL !== 18'h08000 || cu.Read_AC !== 1'b1) begin fails++; $display("FAIL mvtr got %h/%b want 08000/1", cu.Write_RL, cu.Read_AC); end
    do_reset();
    to_exec(8'hE0);
    tests++; if (cu.Op !== 3'b110 || cu.Write_RL !== 18'h1) begin fails++; $display("FAIL clr got %0h/%h want 6/00001", cu.Op, cu.Write_RL); end
  endtask

  task automatic test_mem();
    do_reset();
    to_exec(8'h80);
    tests++; if (cu.Mem_Read !== 1'b1 || cu.Write_RL !== 18'h0) begin fails++; $display("FAIL ldm_exec got %b/%h want 1/0", cu.Mem_Read, cu.Write_RL); end
    step();
    tests++; if (cu.Read_RL !== 15'h4000 || cu.Write_RL !== 18'h1 || cu.busy !== 1'b1) begin fails++; $display("FAIL ldm_mem got %h/%h want 4000/00001", cu.Read_RL, cu.Write_RL); end
    step();
    tests++; if (cu.fetch !== 1'b1) begin fails++; $display("FAIL ldm_cpi got %b want 1", cu.fetch); end
    do_reset();
    to_exec(8'h90);
    tests++; if (cu.Write_RL !== 18'h10000 || cu.Read_AC !== 1'b1) begin fails++; $display("FAIL stm_exec got %h/%b want 10000/1", cu.Write_RL, cu.Read_AC); end
    step();
    tests++; if (cu.Mem_Write !== 1'b1 || cu.Write_RL !== 18'h0) begin fails++; $display("FAIL stm_mem got %b/%h want 1/0", cu.Mem_Write, cu.Write_RL); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    tests++; if (outs() !== 50'h0) begin fails++; $display("FAIL reset_mem got %h want 0", outs()); end
  endtask

  task automatic test_branch();
    do_reset();
    cu.z_flag = 1'b1;
    to_exec(8'hA0);
`ifdef CU_ZERO_BRANCH_EN
    tests++; if ({cu.fetch, cu.PC1} !== 2'b11) begin fails++; $display("FAIL fetchop got %b want 11", {cu.fetch, cu.PC1}); end
    step();
    tests++; if (cu.Ins_Con !== 2'b10 || cu.Write_RL !== 18'h02000) begin fails++; $display("FAIL jmpz_taken got %b/%h want 10/02000", cu.Ins_Con, cu.Write_RL); end
    do_reset();
    cu.z_flag = 1'b0;
    to_exec(8'hA0);
    step();
    tests++; if (cu.Ins_Con !== 2'b00 || cu.Write_RL !== 18'h0) begin fails++; $display("FAIL jmpz_not got %b/%h want 00/0", cu.Ins_Con, cu.Write_RL); end
    do_reset();
    to_exec(8'hB0);
    step();
    tests++; if (cu.Ins_Con !== 2'b10 || cu.Write_RL !== 18'h02000) begin fails++; $display("FAIL jmpnz_taken got %b/%h want 10/02000", cu.Ins_Con, cu.Write_RL); end
    step();
    tests++; if (cu.fetch !== 1'b1) begin fails++; $display("FAIL br_cpi got %b want 1", cu.fetch); end
`else
    tests++; if (cu.fetch !== 1'b0 || cu.busy !== 1'b1 || cu.Ins_Con !== 2'b00 || cu.Write_RL !== 18'h0) begin fails++; $display("FAIL jmpz_nop got %h want busy-only", outs()); end
    step();
    tests++; if (cu.fetch !== 1'b1) begin fails++; $display("FAIL jmpz_cpi got %b want 1", cu.fetch); end
`endif
    cu.z_flag = 1'b0;
  endtask

  task automatic test_halt();
    do_reset();
    to_exec(8'hF0);
    step();
    tests++; if (outs() !== 50'h1) begin fails++; $display("FAIL halt got %h want 1", outs()); end
    launch(8'h13);
    tests++; if (cu.fetch !== 1'b1 || cu.done !== 1'b0) begin fails++; $display("FAIL halt_restart got %b/%b want 1/0", cu.fetch, cu.done); end
    step();
    cu.finish_signal = 1'b1;
    step();
    cu.finish_signal = 1'b0;
    tests++; if (outs() !== 50'h1) begin fails++; $display("FAIL finish got %h want 1", outs()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    to_exec(8'h13);
    step();
    step();
    cu.start = 1'b1;
    step();
    cu.start = 1'b0;
    tests++; if (cu.Decode !== 1'b1) begin fails++; $display("FAIL start_busy got %b want 1", cu.Decode); end
    step();
    tests++; if (cu.Read_RL !== 15'h0008 || cu.Write_RL !== 18'h1) begin fails++; $display("FAIL b2b_exec got %h/%h want 0008/00001", cu.Read_RL, cu.Write_RL); end
  endtask

  initial begin
    cu.start = 1'b0;
    cu.Dec_IN = 8'h00;
    cu.z_flag = 1'b0;
    cu.finish_signal = 1'b0;
    test_reset();
    test_ldac();
    test_alu();
    test_mem();
    test_branch();
    test_halt();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
